// File: rtl/rr_scheduler.sv
// Four-input round-robin merger: pulls words from four source FIFOs into one
// stream under a small INIT/IDLE/ACTIVE/ERROR control FSM.
module rr_scheduler #(
   parameter int unsigned DATA_BITS = 10,
   parameter int unsigned ADDR_BITS = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   init,
   input  logic [ADDR_BITS-1:0]   cfg_high_limit,
   input  logic [ADDR_BITS-1:0]   cfg_low_limit,
   input  logic [3:0]             fifo_empty_in,
   input  logic [3:0]             fifo_error_in,
   input  logic [4*DATA_BITS-1:0] fifo_data_in,
   input  logic                   dest_almost_full,
   output logic [3:0]             fifo_read_out,
   output logic [ADDR_BITS-1:0]   high_limit_out,
   output logic [ADDR_BITS-1:0]   low_limit_out,
   output logic [DATA_BITS-1:0]   data_out,
   output logic                   valid_out,
   output logic [1:0]             state_out,
   output logic                   cfg_error_out,
   output logic                   error_out,
   output logic [7:0]             grant_count_out
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t     state, next_state;
   logic [1:0] last_grant;
   logic [1:0] rd_sel;
   logic [3:0] prev_read;
   logic [1:0] cand;
   logic [1:0] grant_idx;
   logic       grant_found;
   logic       read_ok;

   always_comb begin
      next_state = state;
      case (state)
         ST_INIT:
            if (!init && (cfg_low_limit < cfg_high_limit)) next_state = ST_IDLE;
         ST_IDLE:
            if (|fifo_error_in)       next_state = ST_ERROR;
            else if (init)            next_state = ST_INIT;
            else if (!(&fifo_empty_in)) next_state = ST_ACTIVE;
         ST_ACTIVE:
            if (|fifo_error_in)       next_state = ST_ERROR;
            else if (init)            next_state = ST_INIT;
            else if (&fifo_empty_in)  next_state = ST_IDLE;
         default:
            next_state = ST_ERROR;
      endcase
   end

   // Search starts one past the last grant; a port read last cycle is skipped.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant;
      cand        = last_grant;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = 2'(last_grant + 2'(k));
         if (!grant_found && !fifo_empty_in[cand] && !prev_read[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      read_ok = (state == ST_ACTIVE) && (next_state == ST_ACTIVE) &&
                !dest_almost_full && !reset;
      fifo_read_out = '0;
      if (read_ok && grant_found) fifo_read_out[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_INIT;
         prev_read       <= '0;
         valid_out       <= 1'b0;
         rd_sel          <= '0;
         last_grant      <= 2'd3;
         grant_count_out <= '0;
         high_limit_out  <= '0;
         low_limit_out   <= '0;
      end else begin
         state     <= next_state;
         prev_read <= fifo_read_out;
         // An issued read always completes next cycle, whatever the FSM does.
         valid_out <= |fifo_read_out;
         if (state == ST_INIT) begin
            high_limit_out <= cfg_high_limit;
            low_limit_out  <= cfg_low_limit;
         end
         if (|fifo_read_out) begin
            rd_sel          <= grant_idx;
            last_grant      <= grant_idx;
            grant_count_out <= grant_count_out + 8'd1;
         end
      end
   end

   // Source FIFOs present read data the cycle after the strobe.
   assign data_out      = valid_out ? fifo_data_in[rd_sel*DATA_BITS +: DATA_BITS] : '0;
   assign state_out     = state;
   assign error_out     = (state == ST_ERROR);
   assign cfg_error_out = (state == ST_INIT) && (cfg_low_limit >= cfg_high_limit);

endmodule

// File: tb/tb_rr_scheduler.sv
// Directed bench for rr_scheduler: hand-computed expectations checked with
// immediate assertions one cycle window at a time.
module tb_rr_scheduler;
   localparam int unsigned DB = 10;
   localparam int unsigned AB = 3;

   logic          clk = 1'b0;
   logic          reset, init, dest_almost_full;
   logic [AB-1:0] cfg_high_limit, cfg_low_limit;
   logic [3:0]    fifo_empty_in, fifo_error_in;
   logic [4*DB-1:0] fifo_data_in;
   logic [3:0]    fifo_read_out;
   logic [AB-1:0] high_limit_out, low_limit_out;
   logic [DB-1:0] data_out;
   logic          valid_out, cfg_error_out, error_out;
   logic [1:0]    state_out;
   logic [7:0]    grant_count_out;

   int n_cmp = 0;
   int n_err = 0;
   logic [DB-1:0] dval [4];

   rr_scheduler #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
      .clk(clk), .reset(reset), .init(init),
      .cfg_high_limit(cfg_high_limit), .cfg_low_limit(cfg_low_limit),
      .fifo_empty_in(fifo_empty_in), .fifo_error_in(fifo_error_in),
      .fifo_data_in(fifo_data_in), .dest_almost_full(dest_almost_full),
      .fifo_read_out(fifo_read_out), .high_limit_out(high_limit_out),
      .low_limit_out(low_limit_out), .data_out(data_out), .valid_out(valid_out),
      .state_out(state_out), .cfg_error_out(cfg_error_out), .error_out(error_out),
      .grant_count_out(grant_count_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      dval[0] = 10'h011; dval[1] = 10'h122; dval[2] = 10'h233; dval[3] = 10'h344;
      fifo_data_in = {dval[3], dval[2], dval[1], dval[0]};
      reset = 1'b1; init = 1'b0; dest_almost_full = 1'b0;
      cfg_high_limit = '0; cfg_low_limit = '0;
      fifo_empty_in = 4'hF; fifo_error_in = 4'h0;

      repeat (2) step();
      chk("rst_state", 32'(state_out), 0);
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_count", 32'(grant_count_out), 0);
      chk("rst_high", 32'(high_limit_out), 0);
      chk("rst_low", 32'(low_limit_out), 0);
      chk("rst_err", 32'(error_out), 0);

      reset = 1'b0; init = 1'b1; cfg_high_limit = 3'd6; cfg_low_limit = 3'd2;
      step();
      init = 1'b0; #1;
      chk("init_hold_state", 32'(state_out), 0);
      chk("init_high", 32'(high_limit_out), 6);
      chk("init_low", 32'(low_limit_out), 2);
      chk("init_cfg_ok", 32'(cfg_error_out), 0);
      step();
      chk("to_idle", 32'(state_out), 1);

      init = 1'b1;
      step();
      chk("idle_to_init", 32'(state_out), 0);
      init = 1'b0; cfg_high_limit = 3'd2; cfg_low_limit = 3'd5; #1;
      chk("cfg_err_gt", 32'(cfg_error_out), 1);
      step();
      chk("cfg_err_stay", 32'(state_out), 0);
      chk("cfg_err_high", 32'(high_limit_out), 2);
      chk("cfg_err_low", 32'(low_limit_out), 5);
      cfg_high_limit = 3'd4; cfg_low_limit = 3'd4; #1;
      chk("cfg_err_eq", 32'(cfg_error_out), 1);
      step();
      chk("cfg_eq_stay", 32'(state_out), 0);
      cfg_high_limit = 3'd6; cfg_low_limit = 3'd2; #1;
      chk("cfg_ok", 32'(cfg_error_out), 0);
      step();
      chk("reidle", 32'(state_out), 1);
      cfg_high_limit = 3'd7; cfg_low_limit = 3'd1;
      step();
      chk("hold_high", 32'(high_limit_out), 6);
      chk("hold_low", 32'(low_limit_out), 2);

      fifo_empty_in = 4'h0; #1;
      chk("idle_no_read", 32'(fifo_read_out), 0);
      step();
      chk("to_active", 32'(state_out), 2);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr_read%0d", k), 32'(fifo_read_out), 32'(1 << (k % 4)));
         chk($sformatf("rr_valid%0d", k), 32'(valid_out), (k > 0) ? 1 : 0);
         chk($sformatf("rr_data%0d", k), 32'(data_out), (k > 0) ? 32'(dval[(k-1)%4]) : 0);
         chk($sformatf("rr_count%0d", k), 32'(grant_count_out), 32'(k));
         step();
      end

      dest_almost_full = 1'b1; #1;
      chk("bp_read", 32'(fifo_read_out), 0);
      chk("bp_valid", 32'(valid_out), 1);
      chk("bp_data", 32'(data_out), 32'(dval[0]));
      chk("bp_count", 32'(grant_count_out), 5);
      step();
      chk("bp_read2", 32'(fifo_read_out), 0);
      chk("bp_valid2", 32'(valid_out), 0);
      chk("bp_data2", 32'(data_out), 0);
      chk("bp_count2", 32'(grant_count_out), 5);
      dest_almost_full = 1'b0; #1;
      chk("bp_resume", 32'(fifo_read_out), 4'b0010);
      step();

      fifo_empty_in = 4'b1011; #1;
      chk("solo_read0", 32'(fifo_read_out), 4'b0100);
      chk("solo_data0", 32'(data_out), 32'(dval[1]));
      chk("solo_count0", 32'(grant_count_out), 6);
      step();
      chk("solo_read1", 32'(fifo_read_out), 0);
      chk("solo_data1", 32'(data_out), 32'(dval[2]));
      step();
      chk("solo_read2", 32'(fifo_read_out), 4'b0100);
      chk("solo_valid2", 32'(valid_out), 0);
      step();

      fifo_empty_in = 4'hF; #1;
      chk("drain_read", 32'(fifo_read_out), 0);
      chk("drain_valid", 32'(valid_out), 1);
      chk("drain_data", 32'(data_out), 32'(dval[2]));
      chk("drain_count", 32'(grant_count_out), 8);
      step();
      chk("drain_idle", 32'(state_out), 1);
      chk("drain_valid2", 32'(valid_out), 0);

      fifo_empty_in = 4'h0;
      step();
      chk("err_active", 32'(state_out), 2);
      chk("err_pre_read", 32'(fifo_read_out), 4'b1000);
      step();
      fifo_error_in = 4'b0010; init = 1'b1; #1;
      chk("err_no_read", 32'(fifo_read_out), 0);
      chk("err_inflight", 32'(data_out), 32'(dval[3]));
      step();
      chk("err_state", 32'(state_out), 3);
      chk("err_flag", 32'(error_out), 1);
      chk("err_read", 32'(fifo_read_out), 0);
      fifo_error_in = 4'h0; init = 1'b0;
      step();
      chk("err_sticky", 32'(state_out), 3);
      chk("err_sticky_read", 32'(fifo_read_out), 0);
      chk("err_count", 32'(grant_count_out), 9);
      chk("err_valid", 32'(valid_out), 0);

      reset = 1'b1;
      step();
      chk("rst2_state", 32'(state_out), 0);
      chk("rst2_err", 32'(error_out), 0);
      chk("rst2_count", 32'(grant_count_out), 0);
      reset = 1'b0;
      step();
      chk("rst2_idle", 32'(state_out), 1);
      step();
      chk("rst2_active", 32'(state_out), 2);
      chk("rst2_read", 32'(fifo_read_out), 4'b0001);
      reset = 1'b1;
      step();
      chk("midrst_valid", 32'(valid_out), 0);
      chk("midrst_data", 32'(data_out), 0);
      chk("midrst_state", 32'(state_out), 0);
      reset = 1'b0;
      step();
      step();
      chk("wrap_start", 32'(grant_count_out), 0);
      repeat (255) step();
      chk("wrap_255", 32'(grant_count_out), 255);
      step();
      chk("wrap_0", 32'(grant_count_out), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
